regfile_wb_arbiter: RTL
=======================

Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port (4-bit enable select, active-low RFE, 32-bit write data) between two writeback sources: the ALU and the load unit.
- Each source has a VALID/READY handshake into a one-entry holding register.
- One write is issued per cycle by fixed priority with an anti-starvation counter and a same-destination ordering rule.
- Outputs are registered and drive the register file's enable decoder and data input directly. It also exports a pending-destination vector for read-hazard stalls.

Parameters:
DW, 32, write data width
AW, 4, register select width (2**AW registers)
STARVE_MAX, 3, consecutive ALU losses before ALU is forced to win (1..15)

Ports:
CLK  in  1  clock; all state on posedge
CLR  in  1  synchronous active-low reset
ALU_VALID  in  1  ALU writeback request
ALU_READY  out  1  ALU holding register can accept this cycle
ALU_RD  in  AW  ALU destination register
ALU_DATA  in  DW  ALU result
LD_VALID  in  1  load writeback request
LD_READY  out  1  load holding register can accept this cycle
LD_RD  in  AW  load destination register
LD_DATA  in  DW  load data
WSEL  out  AW  register select to write-enable decoder (registered)
WDATA  out  DW  write data to register file data input (registered)
RFE  out  1  active-low write enable to decoder (registered; 1 = no write)
PEND  out  2**AW  one bit per register with an accepted, not-yet-issued write

Behaviour:
- Reset (CLR=0 at posedge):
  - both holding registers empty, age bit 0, starvation count 0.
  - WSEL=0, WDATA=0, RFE=1.
  - ALU_READY=LD_READY=0 while CLR=0.
  - Reset mid-operation discards held writes; no partial write is issued.
- Holding register per source (EMPTY/FULL): an accept happens at a posedge with VALID&READY.
  - READY = CLR & (EMPTY | that source issues this cycle). Same-cycle drain+refill is allowed.
  - READY depends only on state, never on VALID, so there is no combinational loop.
- Issue decision is combinational from holding state only:
  - only ALU full -> ALU; only LD full -> LD.
  - both full, same RD -> the older entry issues (age bit records which was accepted first). If both were accepted on the same edge, ALU is older.
  - both full, different RD -> LD wins, unless starve count == STARVE_MAX, then ALU wins.
- Starvation counter:
  - increments when ALU is full and loses.
  - resets to 0 when ALU issues or ALU is empty.
  - saturates at STARVE_MAX.
- Output register: on the issue edge, WSEL<=RD, WDATA<=data, RFE<=0, and the winner becomes EMPTY unless refilled. With no issue, RFE<=1 and WSEL/WDATA hold their last values.
- Latency: accept at edge N -> earliest RFE=0 after edge N+1 -> register file captures at edge N+2. Sustained throughput is one write per cycle total.
- PEND: OR of one-hot(RD) for each FULL holding register. It covers only the issue window, not the in-flight output register.
- RFE=0 is never asserted for two sources in the same cycle, and no write is ever lost or duplicated.
- Same-RD writes always reach the register file in acceptance order.
- All RD values 0..15 are legal, including R15; there is no special casing.

Decomposition:
- Shared package: AW, DW, the source-ID encoding (SRC_ALU=0, SRC_LD=1), the RFE idle level (1), and the STARVE_MAX default.
- One natural sub-module: wb_hold_slot (one-entry VALID/READY holding register with RD/data and a full flag), instantiated twice. The arbiter, age bit, starvation counter and output register stay in the top.

Test Plan:
- Reset: drive CLR=0 for 2 cycles with both VALIDs high -> READYs=0, RFE=1, WSEL=0, WDATA=0, PEND=0. Release -> READYs=1 next cycle.
- Single ALU write: ALU_RD=5, ALU_DATA=0xDEADBEEF accepted at edge N -> PEND[5]=1 after N. After N+1: RFE=0, WSEL=5, WDATA=0xDEADBEEF, PEND=0. After N+2: RFE=1.
- Priority and starvation (STARVE_MAX=3): hold both VALIDs high, ALU_RD=1, LD_RD=2, continuously -> issue order LD, LD, LD, ALU, repeating. ALU_READY=1 only on its issue cycles.
- Same-destination ordering: ALU_RD=7 data 0x11 accepted at edge N, LD_RD=7 data 0x22 accepted at N+1 -> writes issue ALU (0x11) then LD (0x22); final R7=0x22. Repeat with both accepted on the same edge -> same order.
- Back-to-back refill: LD_VALID held high with RD 0,1,2,3 on consecutive cycles, ALU idle -> four consecutive RFE=0 cycles with WSEL 0,1,2,3, and LD_READY never drops.
- Reset mid-operation: both slots full (RD 3 and 4), CLR=0 for one edge -> no further RFE=0, PEND=0, and the register file retains its old R3/R4 values.

Source files
------------

// File: rtl/regfile_wb_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter_pkg
// Shared constants and types for the register-file writeback arbiter:
//   AW / DW            default register-select and data widths
//   STARVE_MAX_DEFAULT default number of consecutive ALU losses tolerated
//   src_e              writeback source identifier (ALU = 0, load = 1)
//   slot_state_e       holding-register occupancy
//   RFE_IDLE           level of the active-low write enable when not writing
// ---------------------------------------------------------------------------
package regfile_wb_arbiter_pkg;

  localparam int AW                 = 4;
  localparam int DW                 = 32;
  localparam int STARVE_MAX_DEFAULT = 3;

  localparam logic RFE_IDLE = 1'b1;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LD  = 1'b1
  } src_e;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/regfile_wb_arbiter_wb_hold_slot.sv
// ---------------------------------------------------------------------------
// wb_hold_slot
// One-entry VALID/READY holding register for a single writeback source.
// Ports:
//   clk_i, rst_ni     clock, synchronous active-low reset
//   valid_i/ready_o   upstream handshake; accept on a posedge with both high
//   rd_i, data_i      destination register and write data from the source
//   issue_i           arbiter is draining this slot on the coming edge
//   full_o            slot holds a write that has not been issued yet
//   rd_o, data_o      held destination register and write data
// ---------------------------------------------------------------------------
module wb_hold_slot #(
  parameter int DW = regfile_wb_arbiter_pkg::DW,
  parameter int AW = regfile_wb_arbiter_pkg::AW
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          valid_i,
  output logic          ready_o,
  input  logic [AW-1:0] rd_i,
  input  logic [DW-1:0] data_i,
  input  logic          issue_i,
  output logic          full_o,
  output logic [AW-1:0] rd_o,
  output logic [DW-1:0] data_o
);
  import regfile_wb_arbiter_pkg::*;

  slot_state_e   state_q, state_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [DW-1:0] data_q, data_d;

  // Ready depends only on occupancy and the issue decision, never on valid_i,
  // so a slot being drained can be refilled on the same edge.
  assign ready_o = rst_ni && ((state_q == SLOT_EMPTY) || issue_i);

  // A refill on the draining edge must win over the drain.
  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    data_d  = data_q;
    if (issue_i) begin
      state_d = SLOT_EMPTY;
    end
    if (valid_i && ready_o) begin
      state_d = SLOT_FULL;
      rd_d    = rd_i;
      data_d  = data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= SLOT_EMPTY;
      rd_q    <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
    end
  end

  assign full_o = (state_q == SLOT_FULL);
  assign rd_o   = rd_q;
  assign data_o = data_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter
// Shares the register file's single write port between the ALU and the load
// unit. Each source feeds a one-entry holding slot; one write per cycle is
// issued into a registered WSEL/WDATA/RFE output.
// Ports:
//   CLK, CLR                        clock, synchronous active-low reset
//   ALU_VALID/ALU_READY/ALU_RD/ALU_DATA   ALU writeback handshake
//   LD_VALID/LD_READY/LD_RD/LD_DATA       load writeback handshake
//   WSEL, WDATA, RFE                registered write port (RFE active low)
//   PEND                            one bit per register with a held write
// ---------------------------------------------------------------------------
module regfile_wb_arbiter #(
  parameter int DW         = regfile_wb_arbiter_pkg::DW,
  parameter int AW         = regfile_wb_arbiter_pkg::AW,
  parameter int STARVE_MAX = regfile_wb_arbiter_pkg::STARVE_MAX_DEFAULT
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             ALU_VALID,
  output logic             ALU_READY,
  input  logic [AW-1:0]    ALU_RD,
  input  logic [DW-1:0]    ALU_DATA,
  input  logic             LD_VALID,
  output logic             LD_READY,
  input  logic [AW-1:0]    LD_RD,
  input  logic [DW-1:0]    LD_DATA,
  output logic [AW-1:0]    WSEL,
  output logic [DW-1:0]    WDATA,
  output logic             RFE,
  output logic [2**AW-1:0] PEND
);
  import regfile_wb_arbiter_pkg::*;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic          aluFull, ldFull;
  logic [AW-1:0] aluRd, ldRd;
  logic [DW-1:0] aluData, ldData;
  logic          aluIssue, ldIssue, issueValid;
  src_e          winSrc;
  logic          aluAcc, ldAcc;

  logic          ldOlder_q, ldOlder_d;
  logic [3:0]    starve_q, starve_d;
  logic [AW-1:0] wsel_q, wsel_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          rfe_q, rfe_d;

  wb_hold_slot #(.DW(DW), .AW(AW)) u_alu_slot (
    .clk_i  (CLK),
    .rst_ni (CLR),
    .valid_i(ALU_VALID),
    .ready_o(ALU_READY),
    .rd_i   (ALU_RD),
    .data_i (ALU_DATA),
    .issue_i(aluIssue),
    .full_o (aluFull),
    .rd_o   (aluRd),
    .data_o (aluData)
  );

  wb_hold_slot #(.DW(DW), .AW(AW)) u_ld_slot (
    .clk_i  (CLK),
    .rst_ni (CLR),
    .valid_i(LD_VALID),
    .ready_o(LD_READY),
    .rd_i   (LD_RD),
    .data_i (LD_DATA),
    .issue_i(ldIssue),
    .full_o (ldFull),
    .rd_o   (ldRd),
    .data_o (ldData)
  );

  assign aluAcc = ALU_VALID && ALU_READY;
  assign ldAcc  = LD_VALID && LD_READY;

  // Winner selection uses only slot state. Same destination forces program
  // order via the age bit; otherwise the load wins unless the ALU has lost
  // STARVE_MAX times in a row.
  always_comb begin
    issueValid = aluFull || ldFull;
    winSrc     = SRC_LD;
    if (aluFull && !ldFull) begin
      winSrc = SRC_ALU;
    end else if (aluFull && ldFull) begin
      if (aluRd == ldRd) begin
        winSrc = ldOlder_q ? SRC_LD : SRC_ALU;
      end else if (starve_q == STARVE_LIM) begin
        winSrc = SRC_ALU;
      end
    end
  end

  assign aluIssue = issueValid && (winSrc == SRC_ALU);
  assign ldIssue  = issueValid && (winSrc == SRC_LD);

  // The age bit only matters while both slots are full, so it is updated
  // whenever one slot is filled while the other keeps its entry. A
  // simultaneous accept makes the ALU the older one.
  always_comb begin
    ldOlder_d = ldOlder_q;
    if (aluAcc && ldAcc) begin
      ldOlder_d = 1'b0;
    end else if (aluAcc && ldFull && !ldIssue) begin
      ldOlder_d = 1'b1;
    end else if (ldAcc && aluFull && !aluIssue) begin
      ldOlder_d = 1'b0;
    end
  end

  // The ALU can only lose while full, so any other situation clears the count.
  always_comb begin
    starve_d = 4'd0;
    if (aluFull && !aluIssue) begin
      starve_d = (starve_q == STARVE_LIM) ? starve_q : starve_q + 4'd1;
    end
  end

  // WSEL/WDATA keep their last values on idle cycles; only RFE goes idle.
  always_comb begin
    wsel_d  = wsel_q;
    wdata_d = wdata_q;
    rfe_d   = RFE_IDLE;
    if (aluIssue) begin
      wsel_d  = aluRd;
      wdata_d = aluData;
      rfe_d   = ~RFE_IDLE;
    end else if (ldIssue) begin
      wsel_d  = ldRd;
      wdata_d = ldData;
      rfe_d   = ~RFE_IDLE;
    end
  end

  always_ff @(posedge CLK) begin
    if (!CLR) begin
      ldOlder_q <= 1'b0;
      starve_q  <= 4'd0;
      wsel_q    <= '0;
      wdata_q   <= '0;
      rfe_q     <= RFE_IDLE;
    end else begin
      ldOlder_q <= ldOlder_d;
      starve_q  <= starve_d;
      wsel_q    <= wsel_d;
      wdata_q   <= wdata_d;
      rfe_q     <= rfe_d;
    end
  end

  assign WSEL  = wsel_q;
  assign WDATA = wdata_q;
  assign RFE   = rfe_q;

  always_comb begin
    PEND = '0;
    if (aluFull) begin
      PEND[aluRd] = 1'b1;
    end
    if (ldFull) begin
      PEND[ldRd] = 1'b1;
    end
  end

endmodule
